// File: rtl/pipe_hazard_ctrl.sv
// Interlock/flush controller for the five-stage DLX pipeline.
// Without forwarding, a register written by an in-flight instruction cannot
// be read in decode until the instruction leaves WB. Decode stalls while that
// is the case, and IF/ID is flushed when EX resolves a taken branch or jump.
// Saturating statistics counters track stalls and flushes.

// One scoreboard slot compare: does this in-flight destination feed ID?
module pipe_hazard_sb_entry (
  input  logic       vld,
  input  logic [4:0] dest,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       hit
);
  // r0 is hardwired zero, so it never creates a dependency
  assign hit = vld && (dest != 5'd0) &&
               ((use_rs1 && (dest == rs1)) || (use_rs2 && (dest == rs2)));
endmodule

module pipe_hazard_ctrl #(
  parameter int PEND_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock2,
  input  logic             reset2,
  input  logic [31:0]      inst_id,
  input  logic             id_valid,
  input  logic             branch_taken_ex,
  output logic             stall_id,
  output logic             flush_ifid,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] stall_events,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b001010;
  localparam logic [5:0] OP_BEQZ  = 6'b100000;
  localparam logic [5:0] OP_BNEZ  = 6'b100001;
  localparam logic [5:0] OP_RTYPE = 6'b110000;

  logic [5:0] opcode;
  logic [4:0] rs1, rs2, rd_i, rd_r;
  logic       is_alui;
  logic       use_rs1, use_rs2;
  logic [4:0] dest;

  // In-flight destinations; index 1 = EX, index PEND_DEPTH = WB
  logic [PEND_DEPTH:1]      vld_pipe;
  logic [PEND_DEPTH:1][4:0] dest_pipe;
  logic [PEND_DEPTH:1]      hit;

  logic   hazard;
  logic   issue_vld;
  state_t state_q, state_d;

  assign opcode  = inst_id[31:26];
  assign rs1     = inst_id[25:21];
  assign rs2     = inst_id[20:16];
  assign rd_i    = inst_id[20:16];
  assign rd_r    = inst_id[15:11];
  assign is_alui = (opcode[5:4] == 2'b01);

  // Per-opcode source usage and destination; J and unknown opcodes do neither
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dest    = 5'd0;
    if (opcode == OP_RTYPE) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
      dest    = rd_r;
    end else if (opcode == OP_SW) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
    end else if ((opcode == OP_LW) || is_alui) begin
      use_rs1 = 1'b1;
      dest    = rd_i;
    end else if ((opcode == OP_BEQZ) || (opcode == OP_BNEZ)) begin
      use_rs1 = 1'b1;
    end
  end

  genvar k;
  generate
    for (k = 1; k <= PEND_DEPTH; k++) begin : g_sb
      pipe_hazard_sb_entry u_ent (
        .vld     (vld_pipe[k]),
        .dest    (dest_pipe[k]),
        .rs1     (rs1),
        .rs2     (rs2),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .hit     (hit[k])
      );
    end
  endgenerate

  // The WB slot still counts: regfile write and decode read share an edge
  assign hazard     = id_valid && (|hit);
  assign flush_ifid = branch_taken_ex;
  assign stall_id   = hazard && !branch_taken_ex;
  // Only a real, issuing instruction with a nonzero destination is tracked
  assign issue_vld  = id_valid && !stall_id && !flush_ifid && (dest != 5'd0);

  // Advance the scoreboard one stage; a stalled/flushed ID issues a bubble
  always_ff @(posedge clock2 or negedge reset2) begin
    if (!reset2) begin
      vld_pipe  <= '0;
      dest_pipe <= '0;
    end else begin
      for (int i = PEND_DEPTH; i >= 2; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        dest_pipe[i] <= dest_pipe[i-1];
      end
      vld_pipe[1]  <= issue_vld;
      dest_pipe[1] <= issue_vld ? dest : 5'd0;
    end
  end

  // Next state: flush wins over stall
  always_comb begin
    state_d = ST_RUN;
    if (flush_ifid)    state_d = ST_FLUSH;
    else if (stall_id) state_d = ST_STALL;
  end

  // State register
  always_ff @(posedge clock2 or negedge reset2) begin
    if (!reset2) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  assign ctrl_state = state_q;

  // Saturating statistics; a counter at all-ones simply holds
  always_ff @(posedge clock2 or negedge reset2) begin
    if (!reset2) begin
      stall_cycles <= '0;
      stall_events <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_id && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if ((state_d == ST_STALL) && (state_q != ST_STALL) && (stall_events != '1))
        stall_events <= stall_events + CNT_W'(1);
      if (flush_ifid && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build plus a CNT_W=4 build
// sharing the same stimulus, used for the counter saturation scenario.
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2;

  logic        clock2 = 1'b0;
  logic        reset2;
  logic [31:0] inst_id;
  logic        id_valid;
  logic        branch_taken_ex;

  logic        stall_id, flush_ifid;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cycles, stall_events, flush_count;

  logic        s_stall_id, s_flush_ifid;
  logic [1:0]  s_ctrl_state;
  logic [3:0]  s_stall_cycles, s_stall_events, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clock2 = ~clock2;

  pipe_hazard_ctrl #(.PEND_DEPTH(3), .CNT_W(16)) dut (
    .clock2(clock2), .reset2(reset2), .inst_id(inst_id), .id_valid(id_valid),
    .branch_taken_ex(branch_taken_ex), .stall_id(stall_id), .flush_ifid(flush_ifid),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .stall_events(stall_events),
    .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.PEND_DEPTH(3), .CNT_W(4)) dut_s (
    .clock2(clock2), .reset2(reset2), .inst_id(inst_id), .id_valid(id_valid),
    .branch_taken_ex(branch_taken_ex), .stall_id(s_stall_id), .flush_ifid(s_flush_ifid),
    .ctrl_state(s_ctrl_state), .stall_cycles(s_stall_cycles), .stall_events(s_stall_events),
    .flush_count(s_flush_count)
  );

  function automatic logic [31:0] addi(input int rd, input int rs, input int imm);
    return {6'b010000, 5'(rs), 5'(rd), 16'(imm)};
  endfunction
  function automatic logic [31:0] add(input int rd, input int ra, input int rb);
    return {6'b110000, 5'(ra), 5'(rb), 5'(rd), 11'h020};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs);
    return {6'b000010, 5'(rs), 5'(rd), 16'h0000};
  endfunction
  function automatic logic [31:0] sw(input int rsrc, input int rbase);
    return {6'b001010, 5'(rbase), 5'(rsrc), 16'h0000};
  endfunction

  task automatic drv(input logic [31:0] inst, input logic v, input logic br);
    inst_id = inst; id_valid = v; branch_taken_ex = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clock2); #1;
  endtask

  task automatic apply_reset();
    @(negedge clock2);
    reset2 = 1'b0; inst_id = '0; id_valid = 1'b0; branch_taken_ex = 1'b0;
    @(negedge clock2);
    reset2 = 1'b1;
  endtask

  task automatic test_reset();
    reset2 = 1'b0;
    drv(32'h0, 1'b0, 1'b1);
    checks++; if (flush_ifid !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", flush_ifid); end
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall_id); end
    tick();
    checks++; if (ctrl_state !== RUN) begin errors++; $display("FAIL rst_state got %0d want 0", ctrl_state); end
    checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL rst_flush_count got %0d want 0", flush_count); end
    checks++; if (stall_cycles !== 16'd0 || stall_events !== 16'd0) begin errors++; $display("FAIL rst_stall_cnts got %0d/%0d want 0/0", stall_cycles, stall_events); end
    checks++; if (s_flush_count !== 4'd0) begin errors++; $display("FAIL rst_s_flush_count got %0d want 0", s_flush_count); end
    branch_taken_ex = 1'b0;
  endtask

  task automatic test_raw();
    apply_reset();
    drv(addi(3, 1, 5), 1'b1, 1'b0);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL raw_producer_stall got %b want 0", stall_id); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(add(4, 3, 2), 1'b1, 1'b0);
      checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL raw_stall[%0d] got %b want 1", i, stall_id); end
      checks++; if (ctrl_state !== (i == 0 ? RUN : STALL)) begin errors++; $display("FAIL raw_state[%0d] got %0d want %0d", i, ctrl_state, (i == 0 ? RUN : STALL)); end
      tick();
    end
    drv(add(4, 3, 2), 1'b1, 1'b0);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", stall_id); end
    checks++; if (ctrl_state !== STALL) begin errors++; $display("FAIL raw_state_last got %0d want 1", ctrl_state); end
    tick();
    drv(32'h0, 1'b0, 1'b0);
    checks++; if (ctrl_state !== RUN) begin errors++; $display("FAIL raw_state_run got %0d want 0", ctrl_state); end
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL raw_stall_cycles got %0d want 3", stall_cycles); end
    checks++; if (stall_events !== 16'd1) begin errors++; $display("FAIL raw_stall_events got %0d want 1", stall_events); end
  endtask

  task automatic test_r0();
    apply_reset();
    drv(addi(0, 1, 1), 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(add(4, 0, 2), 1'b1, 1'b0);
      checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL r0_stall[%0d] got %b want 0", i, stall_id); end
      tick();
    end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL r0_stall_cycles got %0d want 0", stall_cycles); end
  endtask

  task automatic test_lw_sw();
    apply_reset();
    drv(lw(5, 1), 1'b1, 1'b0);
    tick();
    drv(addi(6, 1, 1), 1'b1, 1'b0);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lwsw_indep got %b want 0", stall_id); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(sw(5, 2), 1'b1, 1'b0);
      checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL lwsw_stall[%0d] got %b want 1", i, stall_id); end
      tick();
    end
    drv(sw(5, 2), 1'b1, 1'b0);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL lwsw_release got %b want 0", stall_id); end
    tick();
    checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL lwsw_stall_cycles got %0d want 2", stall_cycles); end
    checks++; if (stall_events !== 16'd1) begin errors++; $display("FAIL lwsw_stall_events got %0d want 1", stall_events); end
  endtask

  task automatic test_flush();
    apply_reset();
    drv(addi(3, 1, 5), 1'b1, 1'b0);
    tick();
    drv(add(4, 3, 2), 1'b1, 1'b1);
    checks++; if (flush_ifid !== 1'b1) begin errors++; $display("FAIL fl_flush got %b want 1", flush_ifid); end
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", stall_id); end
    tick();
    drv(add(7, 4, 4), 1'b1, 1'b0);
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL fl_dropped_dep got %b want 0", stall_id); end
    checks++; if (ctrl_state !== FLUSH) begin errors++; $display("FAIL fl_state got %0d want 2", ctrl_state); end
    checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL fl_count got %0d want 1", flush_count); end
    checks++; if (stall_cycles !== 16'd0 || stall_events !== 16'd0) begin errors++; $display("FAIL fl_no_stall_cnt got %0d/%0d want 0/0", stall_cycles, stall_events); end
    tick();
    drv(32'h0, 1'b0, 1'b0);
    checks++; if (ctrl_state !== RUN) begin errors++; $display("FAIL fl_state_run got %0d want 0", ctrl_state); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    drv(addi(3, 1, 5), 1'b1, 1'b0);
    tick();
    drv(add(4, 3, 2), 1'b1, 1'b0);
    tick();
    checks++; if (stall_id !== 1'b1 || ctrl_state !== STALL) begin errors++; $display("FAIL mid_pre got %b/%0d want 1/1", stall_id, ctrl_state); end
    reset2 = 1'b0;
    #1;
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL mid_stall got %b want 0", stall_id); end
    checks++; if (ctrl_state !== RUN) begin errors++; $display("FAIL mid_state got %0d want 0", ctrl_state); end
    checks++; if (stall_cycles !== 16'd0 || stall_events !== 16'd0) begin errors++; $display("FAIL mid_cnts got %0d/%0d want 0/0", stall_cycles, stall_events); end
    reset2 = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL mid_release got %b want 0", stall_id); end
    tick();
    drv(32'h0, 1'b0, 1'b0);
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL mid_after got %0d want 0", stall_cycles); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int p = 0; p < 7; p++) begin
      drv(addi(3, 1, 5), 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
        drv(add(4, 3, 2), 1'b1, 1'b0);
        tick();
      end
      drv(add(4, 3, 2), 1'b1, 1'b0);
      tick();
      if (p == 4) begin
        checks++; if (s_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_s_at15 got %0d want 15", s_stall_cycles); end
        checks++; if (stall_cycles !== 16'd15) begin errors++; $display("FAIL sat_at15 got %0d want 15", stall_cycles); end
      end
    end
    checks++; if (s_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_s_hold got %0d want 15", s_stall_cycles); end
    checks++; if (stall_cycles !== 16'd21) begin errors++; $display("FAIL sat_wide got %0d want 21", stall_cycles); end
    checks++; if (s_stall_events !== 4'd7) begin errors++; $display("FAIL sat_s_events got %0d want 7", s_stall_events); end
    for (int i = 0; i < 20; i++) begin
      drv(32'h0, 1'b0, 1'b1);
      tick();
    end
    drv(32'h0, 1'b0, 1'b0);
    checks++; if (s_flush_count !== 4'd15) begin errors++; $display("FAIL sat_s_flush got %0d want 15", s_flush_count); end
    checks++; if (flush_count !== 16'd20) begin errors++; $display("FAIL sat_flush got %0d want 20", flush_count); end
  endtask

  initial begin
    reset2 = 1'b0; inst_id = '0; id_valid = 1'b0; branch_taken_ex = 1'b0;
    test_reset();
    test_raw();
    test_r0();
    test_lw_sw();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
